// File: rtl/prodv_mac_if.sv
// Stream interface of the dot-product engine: operand pairs in, accumulated results out.
// The engine takes the slave side; a producer/consumer takes the master side.
interface prodv_mac_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 19
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] s;
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, s, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, s, ovf
    );
endinterface

// File: rtl/prodv_mac.sv
// Streaming dot-product engine: registered multiply stage feeding an accumulator that
// folds LEN products into one result, with optional signed operands and saturation.
module prodv_mac #(
    parameter int WIDTH    = 8,
    parameter int LEN      = 4,
    parameter int ACC_W    = 2*WIDTH + $clog2(LEN) + 1,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    prodv_mac_if.slave bus
);
    localparam int PW    = 2*WIDTH;
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN-1);

    logic [CNT_W-1:0] cnt_r;
    logic [PW-1:0]    prod_r;
    logic             prod_v_r;
    logic             last_r;
    logic [ACC_W-1:0] acc_r;
    logic             ovf_acc_r;
    logic [ACC_W-1:0] s_r;
    logic             ovf_r;
    logic             out_valid_r;

    logic             in_ready_s;
    logic             accept_s;
    logic [PW-1:0]    ext_a_s;
    logic [PW-1:0]    ext_b_s;
    logic [PW-1:0]    prod_s;
    logic [ACC_W:0]   acc_x_s;
    logic [ACC_W:0]   prod_x_s;
    logic [ACC_W:0]   sum_s;
    logic             this_ovf_s;
    logic [ACC_W-1:0] res_s;

    // The last product in flight blocks intake so a pending result is never overwritten.
    assign in_ready_s = reset & ~clear & ~out_valid_r & ~(prod_v_r & last_r);
    assign accept_s   = bus.in_valid & in_ready_s;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.s         = s_r;
    assign bus.ovf       = ovf_r;

    // Operands widened to product width; low PW bits of the product are exact either way.
    always_comb begin
        if (SIGNED != 0) begin
            ext_a_s = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
            ext_b_s = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
        end else begin
            ext_a_s = {{WIDTH{1'b0}}, bus.a};
            ext_b_s = {{WIDTH{1'b0}}, bus.b};
        end
        prod_s = ext_a_s * ext_b_s;
    end

    // One extra bit of headroom exposes overflow of the accumulate step.
    always_comb begin
        if (SIGNED != 0) begin
            acc_x_s  = {acc_r[ACC_W-1], acc_r};
            prod_x_s = {{(ACC_W+1-PW){prod_r[PW-1]}}, prod_r};
        end else begin
            acc_x_s  = {1'b0, acc_r};
            prod_x_s = {{(ACC_W+1-PW){1'b0}}, prod_r};
        end
        sum_s = acc_x_s + prod_x_s;
        if (SIGNED != 0) begin
            this_ovf_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
        end else begin
            this_ovf_s = sum_s[ACC_W];
        end
        if (this_ovf_s && (SATURATE != 0)) begin
            if (SIGNED != 0) begin
                res_s = sum_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                res_s = {ACC_W{1'b1}};
            end
        end else begin
            res_s = sum_s[ACC_W-1:0];
        end
    end

    // Product stage, accumulate stage and result holding register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r       <= CNT_W'(0);
            prod_r      <= PW'(0);
            prod_v_r    <= 1'b0;
            last_r      <= 1'b0;
            acc_r       <= ACC_W'(0);
            ovf_acc_r   <= 1'b0;
            s_r         <= ACC_W'(0);
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (clear) begin
            cnt_r       <= CNT_W'(0);
            prod_v_r    <= 1'b0;
            acc_r       <= ACC_W'(0);
            ovf_acc_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            if (accept_s) begin
                prod_r   <= prod_s;
                prod_v_r <= 1'b1;
                last_r   <= (cnt_r == CNT_LAST);
                cnt_r    <= (cnt_r == CNT_LAST) ? CNT_W'(0) : cnt_r + CNT_W'(1);
            end else begin
                prod_v_r <= 1'b0;
            end

            if (prod_v_r) begin
                if (last_r) begin
                    s_r         <= res_s;
                    ovf_r       <= ovf_acc_r | this_ovf_s;
                    out_valid_r <= 1'b1;
                    acc_r       <= ACC_W'(0);
                    ovf_acc_r   <= 1'b0;
                end else begin
                    acc_r       <= res_s;
                    ovf_acc_r   <= ovf_acc_r | this_ovf_s;
                end
            end else begin
                acc_r <= acc_r;
            end
        end
    end
endmodule
